ldl_scheduler: RTL and testbench

LDL_SCHEDULER -- requirements
Module: ldl_scheduler

---
 rtl/ldl_pkg.sv | 26 ++
 rtl/ldl_scheduler_if.sv | 49 ++++
 rtl/ldl_rr_arbiter.sv | 34 +++
 rtl/ldl_scheduler.sv | 130 +++++++++++++
 tb/tb_ldl_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ldl_pkg.sv
// ldl_pkg: shared types and defaults for the LDL job scheduler.
//   state_e     - scheduler FSM states (IDLE / RUN / RESP)
//   *_DEF       - default matrix size, element width, hold time and timeout
//   CNT_W       - run-counter width for the default timeout
//   cnt_w()     - run-counter width for an arbitrary timeout
package ldl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int N_DEF       = 3;
    localparam int W_DEF       = 8;
    localparam int HOLD_DEF    = 4;
    localparam int TIMEOUT_DEF = 64;

    // Counter must be able to hold the value TIMEOUT itself.
    localparam int CNT_W = $clog2(TIMEOUT_DEF + 1);

    function automatic int cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ldl_scheduler_if.sv
// ldl_scheduler_if: all handshake and data buses of the LDL scheduler.
//   req0_* / req1_*  - two requesters offering matrices (valid/ready)
//   eng_*            - factorization engine control and result buses
//   rsp_*            - response channel (valid/ready) with id, error, L, D
//   busy             - scheduler not idle
// Modports: slave = scheduler side, master = requesters/engine/consumer side.
interface ldl_scheduler_if #(
    parameter int N = 3,
    parameter int W = 8
);
    localparam int MW = W * N * N;

    logic          req0_valid;
    logic          req1_valid;
    logic          req0_ready;
    logic          req1_ready;
    logic [MW-1:0] req0_matrix;
    logic [MW-1:0] req1_matrix;

    logic          eng_start;
    logic [MW-1:0] eng_matrix;
    logic          eng_done;
    logic [MW-1:0] eng_L;
    logic [MW-1:0] eng_D;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic          rsp_err;
    logic [MW-1:0] rsp_L;
    logic [MW-1:0] rsp_D;

    logic          busy;

    modport slave (
        input  req0_valid, req1_valid, req0_matrix, req1_matrix,
        input  eng_done, eng_L, eng_D, rsp_ready,
        output req0_ready, req1_ready, eng_start, eng_matrix,
        output rsp_valid, rsp_id, rsp_err, rsp_L, rsp_D, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_matrix, req1_matrix,
        output eng_done, eng_L, eng_D, rsp_ready,
        input  req0_ready, req1_ready, eng_start, eng_matrix,
        input  rsp_valid, rsp_id, rsp_err, rsp_L, rsp_D, busy
    );

endinterface

// File: rtl/ldl_rr_arbiter.sv
// ldl_rr_arbiter: two-way round-robin grant with last-grant pointer.
//   clk, rst   - clock, asynchronous active-high reset
//   en_i       - grants allowed this cycle (scheduler idle, not in reset)
//   valid_i    - requester valids, bit k = requester k
//   grant_o    - one-hot grant (or zero); a grant is an accept
//   gid_o      - index of the granted requester
module ldl_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o,
    output logic       gid_o
);

    // last_q = index granted most recently; reset to 1 so req0 goes first.
    logic last_q, last_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            grant_o[0] = valid_i[0] & (~valid_i[1] | last_q);
            grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_q);
        end
        gid_o  = grant_o[1];
        last_d = (|grant_o) ? grant_o[1] : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/ldl_scheduler.sv
// ldl_scheduler: accepts LDL factorization jobs from two requesters
// (round robin), runs the engine for at least HOLD_CYCLES, captures the
// result (or aborts after TIMEOUT run cycles) and returns it on the
// response channel.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - ldl_scheduler_if.slave: requester, engine and response buses
module ldl_scheduler
    import ldl_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int W           = W_DEF,
    parameter int HOLD_CYCLES = HOLD_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    ldl_scheduler_if.slave   bus
);

    localparam int MW = W * N * N;
    localparam int CW = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] TMO_C  = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] mat_q, mat_d;
    logic [MW-1:0] l_q, l_d;
    logic [MW-1:0] d_q, d_d;
    logic          id_q, id_d;
    logic          err_q, err_d;

    logic [1:0]          req_vld;
    logic [1:0][MW-1:0]  req_mat;
    logic [1:0]          grant;
    logic                gid;
    logic                accept;
    logic                arb_en;

    assign req_vld = {bus.req1_valid, bus.req0_valid};
    assign req_mat = {bus.req1_matrix, bus.req0_matrix};

    // Gating with rst keeps both readys low while reset is held.
    assign arb_en = (state_q == ST_IDLE) & ~rst;

    ldl_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .en_i    (arb_en),
        .valid_i (req_vld),
        .grant_o (grant),
        .gid_o   (gid)
    );

    assign accept = |grant;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mat_d   = mat_q;
        l_d     = l_q;
        d_d     = d_q;
        id_d    = id_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mat_d   = req_mat[gid];
                    id_d    = gid;
                    cnt_d   = CW'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                // Done before HOLD_C is stale engine state; capture wins
                // over timeout when both happen in the same cycle.
                if ((cnt_q >= HOLD_C) && bus.eng_done) begin
                    l_d     = bus.eng_L;
                    d_d     = bus.eng_D;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (cnt_q >= TMO_C) begin
                    l_d     = '0;
                    d_d     = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mat_q   <= '0;
            l_q     <= '0;
            d_q     <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mat_q   <= mat_d;
            l_q     <= l_d;
            d_q     <= d_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.eng_start  = (state_q == ST_RUN);
    assign bus.eng_matrix = mat_q;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_err    = err_q;
    assign bus.rsp_L      = l_q;
    assign bus.rsp_D      = d_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ldl_scheduler.sv
// tb_ldl_scheduler: directed scoreboard bench for ldl_scheduler with a
// behavioural LDL engine (programmable done / result-valid timing).
module tb_ldl_scheduler;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int MW   = W * N * N;
    localparam int HOLD = 4;
    localparam int TMO  = 64;

    logic clk, rst;

    ldl_scheduler_if #(.N(N), .W(W)) bus ();

    ldl_scheduler #(.N(N), .W(W), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          id;
        logic          err;
        logic [MW-1:0] l;
        logic [MW-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    int   done_at = 1;
    int   res_at  = 1;
    bit   eng_on  = 1'b1;
    int   cyc     = 0;
    logic [MW-1:0] lr, dr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural engine ----------------
    function automatic void ldl(input logic [MW-1:0] m,
                                output logic [MW-1:0] lo,
                                output logic [MW-1:0] dd);
        int a [N][N];
        int l [N][N];
        int d [N];
        int s;
        lo = '0;
        dd = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a[r][c] = int'(m[W*(r*N+c) +: W]);
                l[r][c] = 0;
            end
        for (int j = 0; j < N; j++) begin
            s = a[j][j];
            for (int k = 0; k < j; k++) s -= l[j][k] * l[j][k] * d[k];
            d[j]    = s;
            l[j][j] = 1;
            for (int i = j + 1; i < N; i++) begin
                s = a[i][j];
                for (int k = 0; k < j; k++) s -= l[i][k] * l[j][k] * d[k];
                l[i][j] = (d[j] != 0) ? s / d[j] : 0;
            end
        end
        for (int r = 0; r < N; r++) begin
            dd[W*(r*N+r) +: W] = W'(d[r]);
            for (int c = 0; c <= r; c++) lo[W*(r*N+c) +: W] = W'(l[r][c]);
        end
    endfunction

    always @(posedge clk) cyc <= bus.eng_start ? cyc + 1 : 0;

    // cyc+1 equals the scheduler's run counter during RUN.
    always_comb begin
        lr = '0;
        dr = '0;
        ldl(bus.eng_matrix, lr, dr);
        bus.eng_done = eng_on && bus.eng_start && (cyc + 1 >= done_at);
        bus.eng_L = '1;
        bus.eng_D = '1;
        if (cyc + 1 >= res_at) begin
            bus.eng_L = lr;
            bus.eng_D = dr;
        end
    end

    // ---------------- matrix helpers ----------------
    function automatic logic [MW-1:0] setel(input logic [MW-1:0] b, input int r,
                                           input int c, input int v);
        b[W*(r*N+c) +: W] = W'(v);
        return b;
    endfunction

    function automatic logic [MW-1:0] sym(input logic [MW-1:0] b, input int r,
                                         input int c, input int v);
        return setel(setel(b, r, c, v), c, r, v);
    endfunction

    // A = L*D*L^T for unit lower L and diagonal D.
    function automatic logic [MW-1:0] mkA(input int d0, d1, d2, l10, l20, l21);
        logic [MW-1:0] m = '0;
        m = sym(m, 0, 0, d0);
        m = sym(m, 1, 0, l10 * d0);
        m = sym(m, 2, 0, l20 * d0);
        m = sym(m, 1, 1, l10 * l10 * d0 + d1);
        m = sym(m, 2, 1, l20 * l10 * d0 + l21 * d1);
        m = sym(m, 2, 2, l20 * l20 * d0 + l21 * l21 * d1 + d2);
        return m;
    endfunction

    function automatic logic [MW-1:0] mkL(input int l10, l20, l21);
        logic [MW-1:0] m = '0;
        m = setel(m, 0, 0, 1); m = setel(m, 1, 1, 1); m = setel(m, 2, 2, 1);
        m = setel(m, 1, 0, l10); m = setel(m, 2, 0, l20); m = setel(m, 2, 1, l21);
        return m;
    endfunction

    function automatic logic [MW-1:0] mkD(input int d0, d1, d2);
        logic [MW-1:0] m = '0;
        m = setel(m, 0, 0, d0); m = setel(m, 1, 1, d1); m = setel(m, 2, 2, d2);
        return m;
    endfunction

    function automatic exp_t mkexp(input logic id, input logic err,
                                   input logic [MW-1:0] l, input logic [MW-1:0] d);
        exp_t e;
        e.id = id; e.err = err; e.l = l; e.d = d;
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic grant_chk(input string tag, input logic [1:0] exp);
        #1;
        chk(tag, MW'({bus.req1_ready, bus.req0_ready}), MW'(exp));
        chk({tag, "_busy"}, MW'(bus.busy), MW'(1'b0));
    endtask

    // Waits for rsp_valid, holds rsp_ready low for bp cycles while checking
    // the payload against the scoreboard head, then completes the handshake.
    task automatic wait_rsp(input int exp_lat, input int bp);
        int   lat = 0;
        exp_t e;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 300);
        chk("rsp_valid", MW'(bus.rsp_valid), MW'(1'b1));
        if (exp_lat > 0) chk("latency", MW'(lat), MW'(exp_lat));
        chk("sb_nonempty", MW'(sb.size() > 0), MW'(1'b1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i <= bp; i++) begin
                if (i > 0) @(negedge clk);
                chk("rsp_valid_hold", MW'(bus.rsp_valid), MW'(1'b1));
                chk("eng_start_resp", MW'(bus.eng_start), MW'(1'b0));
                chk("ready_resp", MW'({bus.req1_ready, bus.req0_ready}), MW'(2'b00));
                chk("rsp_id", MW'(bus.rsp_id), MW'(e.id));
                chk("rsp_err", MW'(bus.rsp_err), MW'(e.err));
                chk("rsp_L", bus.rsp_L, e.l);
                chk("rsp_D", bus.rsp_D, e.d);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic job(input int who, input logic [MW-1:0] m, input exp_t e,
                       input int lat, input int bp);
        @(negedge clk);
        if (who == 0) begin bus.req0_valid = 1'b1; bus.req0_matrix = m; end
        else          begin bus.req1_valid = 1'b1; bus.req1_matrix = m; end
        grant_chk("grant", (who == 0) ? 2'b01 : 2'b10);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp(lat, bp);
    endtask

    // ---------------- stimulus ----------------
    logic [MW-1:0] m0, m1, m2, m3, m4, mspec;

    initial begin
        m0 = mkA(2, 3, 1, 1, 2, 1);
        m1 = mkA(3, 1, 2, 2, 1, 3);
        m2 = mkA(1, 2, 5, 3, 2, 1);
        m3 = mkA(5, 2, 3, 1, 3, 2);
        m4 = mkA(2, 2, 2, 2, 2, 2);
        mspec = '0;
        mspec = sym(mspec, 0, 0, 4);  mspec = sym(mspec, 1, 0, 8);
        mspec = sym(mspec, 2, 0, 4);  mspec = sym(mspec, 1, 1, 20);
        mspec = sym(mspec, 2, 1, 16); mspec = sym(mspec, 2, 2, 29);

        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_matrix = m0;  bus.req1_matrix = m1;
        bus.rsp_ready = 1'b0;

        // reset state, requesters valid throughout
        @(negedge clk); #1;
        chk("rst_ready", MW'({bus.req1_ready, bus.req0_ready}), MW'(2'b00));
        chk("rst_busy", MW'(bus.busy), MW'(1'b0));
        chk("rst_eng_start", MW'(bus.eng_start), MW'(1'b0));
        chk("rst_rsp_valid", MW'(bus.rsp_valid), MW'(1'b0));
        chk("rst_rsp_err", MW'(bus.rsp_err), MW'(1'b0));
        chk("rst_rsp_id", MW'(bus.rsp_id), MW'(1'b0));
        chk("rst_rsp_L", bus.rsp_L, '0);
        chk("rst_rsp_D", bus.rsp_D, '0);
        chk("rst_eng_matrix", bus.eng_matrix, '0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst = 1'b0;

        // contention: both valid every cycle, back-to-back jobs
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; end
            grant_chk("cont_grant", (k % 2) ? 2'b10 : 2'b01);
            if (k % 2) sb.push_back(mkexp(1'b1, 1'b0, mkL(2, 1, 3), mkD(3, 1, 2)));
            else       sb.push_back(mkexp(1'b0, 1'b0, mkL(1, 2, 1), mkD(2, 3, 1)));
            @(posedge clk); #1;
            if (k == 3) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
            wait_rsp(5, 0);
        end

        // single job from req0, nominal latency
        job(0, mspec, mkexp(1'b0, 1'b0, mkL(2, 1, 2), mkD(4, 4, 9)), 5, 0);

        // early done with stale results until run cycle 4
        done_at = 1; res_at = 4;
        job(1, m2, mkexp(1'b1, 1'b0, mkL(3, 2, 1), mkD(1, 2, 5)), 5, 0);

        // done arriving late, at run cycle 7
        done_at = 7; res_at = 1;
        job(0, m3, mkexp(1'b0, 1'b0, mkL(1, 3, 2), mkD(5, 2, 3)), 8, 0);
        done_at = 1;

        // backpressure, with req0 waiting during RESP
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_matrix = m4;
        grant_chk("bp_grant", 2'b10);
        sb.push_back(mkexp(1'b1, 1'b0, mkL(2, 2, 2), mkD(2, 2, 2)));
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_matrix = m0;
        sb.push_back(mkexp(1'b0, 1'b0, mkL(1, 2, 1), mkD(2, 3, 1)));
        wait_rsp(5, 10);
        @(negedge clk);
        grant_chk("bp_next_grant", 2'b01);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_rsp(5, 0);

        // timeout: engine never finishes
        eng_on = 1'b0;
        job(1, m1, mkexp(1'b1, 1'b1, '0, '0), TMO + 1, 0);
        eng_on = 1'b1;

        // reset during RUN at counter 2, then req0 priority restored
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_matrix = m2;
        grant_chk("pre_rst_grant", 2'b01);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("run_eng_start", MW'(bus.eng_start), MW'(1'b1));
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_matrix = m3;
        bus.req1_valid = 1'b1; bus.req1_matrix = m4;
        #1;
        chk("mid_rst_eng_start", MW'(bus.eng_start), MW'(1'b0));
        chk("mid_rst_busy", MW'(bus.busy), MW'(1'b0));
        chk("mid_rst_rsp_valid", MW'(bus.rsp_valid), MW'(1'b0));
        chk("mid_rst_rsp_err", MW'(bus.rsp_err), MW'(1'b0));
        chk("mid_rst_rsp_id", MW'(bus.rsp_id), MW'(1'b0));
        chk("mid_rst_eng_matrix", bus.eng_matrix, '0);
        chk("mid_rst_ready", MW'({bus.req1_ready, bus.req0_ready}), MW'(2'b00));
        @(negedge clk);
        rst = 1'b0;
        grant_chk("post_rst_grant", 2'b01);
        sb.push_back(mkexp(1'b0, 1'b0, mkL(1, 3, 2), mkD(5, 2, 3)));
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_rsp(5, 0);

        chk("sb_drained", MW'(sb.size()), MW'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
